cpu_selftest_ctrl: RTL and testbench

- Synthesizable self-test sequencer that sits beside the single-cycle RV64 core.
- Boot sequence:
  - holds the core in reset;
  - streams a program from a ROM into instruction memory;
  - pads the remaining memory with NOPs;
  - releases the core for a bounded number of cycles;
  - then scans the register file against an expected-value table and reports pass/fail.
- Generalises the fixed 8-instruction, 8-register bench flow to any program length, check count, data width and run budget, and adds early halt.

---
 rtl/cpu_selftest_pkg.sv | 25 ++
 rtl/cpu_selftest_scoreboard.sv | 46 ++++
 rtl/cpu_selftest_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_selftest_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_selftest_pkg.sv
// Shared definitions for the CPU self-test sequencer: the default data
// width, the NOP used to pad instruction memory, the sequencer state
// encoding and a width helper for index/count ports.
package cpu_selftest_pkg;

    localparam int XLEN_DEFAULT = 64;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_selftest_scoreboard.sv
// Result accumulator for the self-test CHECK phase. Compares the register
// file read data against the expected value, counts mismatches (saturating)
// and remembers the register number of the first mismatch.
module cpu_selftest_scoreboard
    import cpu_selftest_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int NUM_CHECK = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  en,
    input  logic [4:0]                            reg_num,
    input  logic [XLEN-1:0]                       actual,
    input  logic [XLEN-1:0]                       expected,
    output logic                                  mismatch,
    output logic [clog2_min1(NUM_CHECK+1)-1:0]    fail_cnt,
    output logic [4:0]                            first_fail_reg
);

    localparam int FCNT_W = clog2_min1(NUM_CHECK + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(NUM_CHECK);

    // x0 needs no special case: the register file already reads it as zero.
    assign mismatch = (actual != expected);

    // Accumulate mismatches and latch the first failing register number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt       <= '0;
            first_fail_reg <= '0;
        end else if (clr) begin
            fail_cnt       <= '0;
            first_fail_reg <= '0;
        end else if (en && mismatch) begin
            if (fail_cnt != FCNT_MAX) begin
                fail_cnt <= fail_cnt + 1'b1;
            end
            if (fail_cnt == '0) begin
                first_fail_reg <= reg_num;
            end
        end
    end

endmodule

// File: rtl/cpu_selftest_ctrl.sv
// Self-test sequencer beside the single-cycle RV64 core. Holds the core in
// reset, copies a program from a synchronous ROM into instruction memory,
// optionally pads the rest of memory with NOPs, lets the core run for a
// bounded number of cycles (or until it halts), then checks the register
// file against an expected-value table.
// Build option: define CPU_SELFTEST_FILL_EN to include the NOP fill phase;
// without it the sequencer goes straight from LOAD to RUN and leaves the
// imem words above the program untouched.
module cpu_selftest_ctrl
    import cpu_selftest_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int IMEM_AW    = 11,
    parameter int PROG_LEN   = 8,
    parameter int NUM_CHECK  = 8,
    parameter int RUN_CYCLES = 100
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic [IMEM_AW-1:0]                    rom_addr,
    input  logic [31:0]                           rom_data,
    output logic                                  imem_we,
    output logic [IMEM_AW-1:0]                    imem_addr,
    output logic [31:0]                           imem_wdata,
    output logic                                  cpu_rst_n,
    input  logic                                  halt,
    output logic [clog2_min1(NUM_CHECK)-1:0]      chk_idx,
    input  logic [4:0]                            chk_reg,
    input  logic [XLEN-1:0]                       chk_val,
    output logic [4:0]                            rf_raddr,
    input  logic [XLEN-1:0]                       rf_rdata,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [clog2_min1(NUM_CHECK+1)-1:0]    fail_cnt,
    output logic [4:0]                            first_fail_reg
);

    localparam int DEPTH  = 1 << IMEM_AW;
    localparam int LCNT_W = IMEM_AW + 1;
    localparam int RCNT_W = clog2_min1(RUN_CYCLES + 1);
    localparam int CIDX_W = clog2_min1(NUM_CHECK);

    localparam logic [LCNT_W-1:0]  LOAD_LAST  = LCNT_W'(PROG_LEN);
    localparam logic [IMEM_AW-1:0] ROM_LAST   = IMEM_AW'(PROG_LEN - 1);
    localparam logic [IMEM_AW-1:0] FILL_FIRST = IMEM_AW'(PROG_LEN);
    localparam logic [IMEM_AW-1:0] ADDR_LAST  = IMEM_AW'(DEPTH - 1);
    localparam logic [RCNT_W-1:0]  RUN_LAST   = RCNT_W'(RUN_CYCLES - 1);
    localparam logic [CIDX_W-1:0]  CHK_LAST   = CIDX_W'(NUM_CHECK - 1);

`ifdef CPU_SELFTEST_FILL_EN
    // A program that fills the whole memory leaves nothing to pad.
    localparam bit FILL_ON = (PROG_LEN < DEPTH);
`else
    localparam bit FILL_ON = 1'b0;
`endif

    state_t state, next_state;

    // Phase counters: LOAD cycle number and RUN cycle number.
    logic [LCNT_W-1:0]  load_cnt,  load_cnt_n;
    logic [RCNT_W-1:0]  run_cnt,   run_cnt_n;

    // load_wr selects the ROM output as write data during LOAD writes;
    // the ROM's own output register already aligns data with imem_addr.
    logic               load_wr,   load_wr_n;
    logic [31:0]        wdata_q,   wdata_n;
    logic               in_check,  in_check_n;

    logic [IMEM_AW-1:0] rom_addr_n, imem_addr_n;
    logic               imem_we_n, cpu_rst_n_n;
    logic [CIDX_W-1:0]  chk_idx_n;
    logic               busy_n, done_n, pass_n;

    logic               sb_clr, sb_en, sb_mismatch;
    logic               start_ok;

    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign sb_clr   = start_ok;
    assign sb_en    = (state == ST_CHECK);

    assign imem_wdata = load_wr ? rom_data : wdata_q;
    assign rf_raddr   = in_check ? chk_reg : 5'd0;

    // State register; async reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: phase transitions on counter terminal values or halt.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_cnt == LOAD_LAST) next_state = FILL_ON ? ST_FILL : ST_RUN;
            end
            ST_FILL: begin
                if (imem_addr == ADDR_LAST) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (halt || (run_cnt == RUN_LAST)) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_idx == CHK_LAST) next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of every registered output, keyed on the
    // state being entered so outputs line up with that state's cycles.
    always_comb begin
        load_cnt_n  = '0;
        run_cnt_n   = '0;
        rom_addr_n  = '0;
        imem_we_n   = 1'b0;
        imem_addr_n = imem_addr;
        load_wr_n   = 1'b0;
        wdata_n     = '0;
        cpu_rst_n_n = 1'b0;
        chk_idx_n   = '0;
        in_check_n  = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        pass_n      = 1'b0;
        case (next_state)
            ST_LOAD: begin
                busy_n = 1'b1;
                if (state == ST_LOAD) begin
                    load_cnt_n = (load_cnt == LOAD_LAST) ? load_cnt : load_cnt + 1'b1;
                end
                rom_addr_n = (load_cnt_n >= LOAD_LAST) ? ROM_LAST : load_cnt_n[IMEM_AW-1:0];
                if (load_cnt_n != '0) begin
                    imem_we_n   = 1'b1;
                    load_wr_n   = 1'b1;
                    imem_addr_n = IMEM_AW'(load_cnt_n - 1'b1);
                end
            end
            ST_FILL: begin
                busy_n    = 1'b1;
                imem_we_n = 1'b1;
                wdata_n   = NOP_INSN;
                if (state == ST_FILL) begin
                    imem_addr_n = (imem_addr == ADDR_LAST) ? imem_addr : imem_addr + 1'b1;
                end else begin
                    imem_addr_n = FILL_FIRST;
                end
            end
            ST_RUN: begin
                busy_n      = 1'b1;
                cpu_rst_n_n = 1'b1;
                if (state == ST_RUN) begin
                    run_cnt_n = (run_cnt == RUN_LAST) ? run_cnt : run_cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                busy_n     = 1'b1;
                in_check_n = 1'b1;
                if (state == ST_CHECK) begin
                    chk_idx_n = (chk_idx == CHK_LAST) ? chk_idx : chk_idx + 1'b1;
                end
            end
            ST_DONE: begin
                done_n = 1'b1;
                // The last entry is compared on the same edge, so fold it in.
                if (state == ST_CHECK) begin
                    pass_n = (fail_cnt == '0) && !sb_mismatch;
                end else begin
                    pass_n = pass;
                end
            end
            default: ;
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            run_cnt   <= '0;
            rom_addr  <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            load_wr   <= 1'b0;
            wdata_q   <= '0;
            cpu_rst_n <= 1'b0;
            chk_idx   <= '0;
            in_check  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            load_cnt  <= load_cnt_n;
            run_cnt   <= run_cnt_n;
            rom_addr  <= rom_addr_n;
            imem_we   <= imem_we_n;
            imem_addr <= imem_addr_n;
            load_wr   <= load_wr_n;
            wdata_q   <= wdata_n;
            cpu_rst_n <= cpu_rst_n_n;
            chk_idx   <= chk_idx_n;
            in_check  <= in_check_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
        end
    end

    cpu_selftest_scoreboard #(
        .XLEN      (XLEN),
        .NUM_CHECK (NUM_CHECK)
    ) u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (sb_clr),
        .en             (sb_en),
        .reg_num        (chk_reg),
        .actual         (rf_rdata),
        .expected       (chk_val),
        .mismatch       (sb_mismatch),
        .fail_cnt       (fail_cnt),
        .first_fail_reg (first_fail_reg)
    );

endmodule

// File: tb/tb_cpu_selftest_ctrl.sv
// Testbench for cpu_selftest_ctrl: synchronous ROM, instruction memory, a
// tiny instruction-level core stand-in and an expected-value table surround
// the sequencer. Expected results come from interpreting the ROM program
// directly and applying the sequencer's timing rules arithmetically.
module tb_cpu_selftest_ctrl;
    import cpu_selftest_pkg::*;

    localparam int XLEN       = 64;
    localparam int IMEM_AW    = 11;
    localparam int PROG_LEN   = 8;
    localparam int NUM_CHECK  = 8;
    localparam int RUN_CYCLES = 100;
    localparam int DEPTH      = 1 << IMEM_AW;
`ifdef CPU_SELFTEST_FILL_EN
    localparam int FILL_LEN = DEPTH - PROG_LEN;
`else
    localparam int FILL_LEN = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               halt = 1'b0;
    logic [IMEM_AW-1:0] rom_addr;
    logic [31:0]        rom_data = '0;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               cpu_rst_n;
    logic [2:0]         chk_idx;
    logic [4:0]         chk_reg;
    logic [XLEN-1:0]    chk_val;
    logic [4:0]         rf_raddr;
    logic [XLEN-1:0]    rf_rdata;
    logic               busy, done, pass;
    logic [3:0]         fail_cnt;
    logic [4:0]         first_fail_reg;

    int errors = 0;
    int checks = 0;

    logic [31:0]     rom     [PROG_LEN];
    logic [31:0]     imem    [DEPTH];
    logic [4:0]      tbl_reg [NUM_CHECK];
    logic [XLEN-1:0] tbl_val [NUM_CHECK];
    logic [XLEN-1:0] rf      [32];
    logic [XLEN-1:0] mrf     [32];
    logic [IMEM_AW-1:0] pc = '0;
    logic clr_rf = 1'b0;
    logic preload = 1'b0;

    cpu_selftest_ctrl #(
        .XLEN(XLEN), .IMEM_AW(IMEM_AW), .PROG_LEN(PROG_LEN),
        .NUM_CHECK(NUM_CHECK), .RUN_CYCLES(RUN_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .halt(halt),
        .chk_idx(chk_idx), .chk_reg(chk_reg), .chk_val(chk_val),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .first_fail_reg(first_fail_reg)
    );

    always #5 clk = ~clk;

    // Executes one instruction; returns 1 when it writes rd.
    function automatic bit exec_word(input logic [31:0] w, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] res);
        logic [63:0] imm;
        imm = {{52{w[31]}}, w[31:20]};
        res = '0;
        if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
            res = a + imm;
            return 1'b1;
        end
        if (w[6:0] == 7'h33) begin
            case (w[14:12])
                3'd0: res = w[30] ? a - b : a + b;
                3'd2: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                3'd4: res = a ^ b;
                3'd6: res = a | b;
                3'd7: res = a & b;
                default: return 1'b0;
            endcase
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Synchronous program ROM: data follows the address by one cycle.
    always @(posedge clk) rom_data <= rom[rom_addr[2:0]];

    // Instruction memory: bench preload or sequencer writes.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) imem[i] <= 32'hDEADBEEF;
        end else if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    // Core stand-in: one instruction per cycle out of reset, state frozen in reset.
    always @(posedge clk) begin : core_model
        logic [63:0] res;
        logic [31:0] w;
        if (clr_rf) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            pc <= '0;
        end else if (cpu_rst_n) begin
            w = imem[pc];
            if (exec_word(w, rf[w[19:15]], rf[w[24:20]], res) && w[11:7] != 5'd0)
                rf[w[11:7]] <= res;
            pc <= pc + 1'b1;
        end else begin
            pc <= '0;
        end
    end

    assign rf_rdata = (rf_raddr == 5'd0) ? '0 : rf[rf_raddr];
    assign chk_reg  = tbl_reg[chk_idx];
    assign chk_val  = tbl_val[chk_idx];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: registers after the first n_exec instructions of the ROM.
    task automatic model_run(input int n_exec);
        logic [63:0] res;
        logic [31:0] w;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        for (int k = 0; k < n_exec && k < PROG_LEN; k++) begin
            w = rom[k];
            if (exec_word(w, mrf[w[19:15]], mrf[w[24:20]], res) && w[11:7] != 5'd0)
                mrf[w[11:7]] = res;
        end
    endtask

    function automatic int run_len(input int halt_at);
        return (halt_at >= 0 && halt_at < RUN_CYCLES) ? halt_at + 1 : RUN_CYCLES;
    endfunction

    task automatic clear_core();
        @(negedge clk); clr_rf = 1'b1;
        @(negedge clk); clr_rf = 1'b0;
    endtask

    // One full sequence; returns start->done latency and observed RUN length.
    task automatic run_seq(input int halt_at, input bit noise, input bit start_in_run,
                           output int lat, output int rlen);
        int cyc;
        bit prev_run;
        clear_core();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", busy, 1);
        check("rom_addr_first", rom_addr, 0);
        cyc = 1; rlen = 0; prev_run = 1'b0;
        while (!done && cyc < 20000) begin
            if (prev_run && !cpu_rst_n) check("check_follows_run", rf_raddr, tbl_reg[0]);
            prev_run = cpu_rst_n;
            halt = 1'b0; start = 1'b0;
            if (cpu_rst_n) begin
                rlen++;
                if (rlen - 1 == halt_at) halt = 1'b1;
                if (start_in_run && rlen == 3) start = 1'b1;
            end else if (noise) begin
                halt = 1'($urandom_range(0, 1));
            end
            @(negedge clk); cyc++;
        end
        halt = 1'b0; start = 1'b0;
        lat = cyc;
        if (!done) check("done_timeout", done, 1);
    endtask

    task automatic verify(input string tag, input int halt_at, input int lat, input int rlen);
        int rexp, nf, ff;
        rexp = run_len(halt_at);
        model_run(rexp);
        nf = 0; ff = 0;
        for (int j = 0; j < NUM_CHECK; j++) begin
            if (mrf[tbl_reg[j]] != tbl_val[j]) begin
                if (nf == 0) ff = int'(tbl_reg[j]);
                nf++;
            end
        end
        check({tag, "_runlen"}, rlen, rexp);
        check({tag, "_latency"}, lat, (PROG_LEN + 1) + FILL_LEN + rexp + NUM_CHECK + 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, (nf == 0) ? 1 : 0);
        check({tag, "_fail_cnt"}, fail_cnt, nf);
        check({tag, "_first_fail"}, first_fail_reg, ff);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom_range(0, 8));
        rs1 = 5'($urandom_range(0, 8));
        rs2 = 5'($urandom_range(0, 8));
        case ($urandom_range(0, 6))
            0: return {12'($urandom_range(0, 4095)), rs1, 3'd0, rd, 7'h13};
            1: return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            2: return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            3: return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            4: return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            5: return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
            default: return {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rlen, w, halt_at;
        logic [31:0] dir_prog [PROG_LEN];
        logic [63:0] dir_vals [NUM_CHECK];
        dir_prog = '{32'h00a00093, 32'h01400113, 32'h002081b3, 32'h40110233,
                     32'h0020f2b3, 32'h0020e333, 32'h0020c3b3, 32'h0020a433};
        dir_vals = '{64'd10, 64'd20, 64'd30, 64'd10, 64'd0, 64'd30, 64'd30, 64'd1};
        for (int k = 0; k < PROG_LEN; k++) rom[k] = dir_prog[k];
        for (int j = 0; j < NUM_CHECK; j++) begin
            tbl_reg[j] = 5'(j + 1);
            tbl_val[j] = dir_vals[j];
        end
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_imem_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_chk_idx", chk_idx, 0);
        check("rst_rf_raddr", rf_raddr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_first_fail", first_fail_reg, 0);
        rst_n = 1'b1;
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;

        // Directed program, matching table
        run_seq(-1, 1'b0, 1'b0, lat, rlen);
        verify("dir", -1, lat, rlen);
        check("dir_pass_const", pass, 1);
        check("dir_fail_const", fail_cnt, 0);
        for (int k = 0; k < PROG_LEN; k++) check($sformatf("imem_%0d", k), imem[k], dir_prog[k]);
`ifdef CPU_SELFTEST_FILL_EN
        check("imem_8_fill", imem[8], 32'h00000013);
        check("imem_last_fill", imem[DEPTH-1], 32'h00000013);
`else
        check("imem_8_kept", imem[8], 32'hDEADBEEF);
        check("imem_last_kept", imem[DEPTH-1], 32'hDEADBEEF);
`endif
        check("done_level", done, 1);

        // Wrong expected value for x3
        tbl_val[2] = 64'd31;
        run_seq(-1, 1'b0, 1'b0, lat, rlen);
        verify("x3bad", -1, lat, rlen);
        check("x3bad_fail_const", fail_cnt, 1);
        check("x3bad_first_const", first_fail_reg, 3);
        tbl_val[2] = 64'd30;

        // Halt on RUN cycle 5
        run_seq(5, 1'b0, 1'b0, lat, rlen);
        verify("halt5", 5, lat, rlen);
        check("halt5_runlen_const", rlen, 6);
        check("halt5_first_const", first_fail_reg, 7);

        // start during RUN is ignored
        run_seq(-1, 1'b0, 1'b1, lat, rlen);
        verify("start_in_run", -1, lat, rlen);

        // Async reset in the middle of FILL (or RUN when FILL is absent)
        clear_core();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!((FILL_LEN > 0) ? (imem_we && imem_addr >= 11'd100) : cpu_rst_n) && w < 5000) begin
            @(negedge clk); w++;
        end
        check("mid_reach", w < 5000, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_imem_we", imem_we, 0);
        check("mid_rst_cpu_rst_n", cpu_rst_n, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        run_seq(-1, 1'b0, 1'b0, lat, rlen);
        verify("after_rst", -1, lat, rlen);

        // Randomised programs, tables and halt points
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < PROG_LEN; k++) rom[k] = rand_instr();
            halt_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
            model_run(run_len(halt_at));
            for (int j = 0; j < NUM_CHECK; j++) begin
                tbl_reg[j] = 5'($urandom_range(0, 8));
                tbl_val[j] = mrf[tbl_reg[j]];
                if ($urandom_range(0, 2) == 0) tbl_val[j] ^= (64'd1 << $urandom_range(0, 63));
            end
            run_seq(halt_at, 1'b1, 1'(t % 2), lat, rlen);
            verify($sformatf("rnd%0d", t), halt_at, lat, rlen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
